// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: reset PC, special instruction encodings and fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction ROM bus: fetch stage drives the word address, ROM returns the word combinationally.
interface if_fetch_unit_if #(
  parameter int IM_AW = 10
);
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_dout;

  modport master (output im_addr, input im_dout);
  modport slave  (input im_addr, output im_dout);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: hold > bubble > load.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        hold,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr_d,
  output logic [31:0] pc4_d,
  output logic        valid_d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_d <= NOP_INSTR;
      pc4_d   <= 32'h0;
      valid_d <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        // pc4_d keeps its old value; it is meaningless while valid_d is low
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end else if (load) begin
        instr_d <= instr_in;
        pc4_d   <= pc4_in;
        valid_d <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC register, ROM addressing and IF/ID capture with stall/redirect/flush.
// Optional macro HALT_DETECT_EN adds a RUN/HALTED FSM that freezes fetch after a syscall.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IM_AW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  if_fetch_unit_if.master    im,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc4_d,
  output logic               valid_d,
  output logic               halted
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;
  logic        halt_q;
  logic        bubble;

  assign pc_plus4    = pc_f + 32'd4;
  assign im.im_addr  = pc_f[IM_AW+1:2];

`ifdef HALT_DETECT_EN
  fetch_state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Only a normal-path capture of a syscall halts; squashed or stalled fetches do not.
  always_comb begin
    state_nxt = state;
    if (state == RUN && !stall && !redirect && !flush && im.im_dout == SYSCALL_INSTR)
      state_nxt = HALTED;
  end

  assign halt_q = (state == HALTED);
`else
  assign halt_q = 1'b0;
`endif

  assign halted = halt_q;

  always_comb begin
    pc_nxt = pc_f;
    if (!stall && !halt_q) begin
      if (redirect) pc_nxt = redirect_pc & 32'hFFFF_FFFC;
      else          pc_nxt = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_f <= RESET_PC;
    else     pc_f <= pc_nxt;
  end

  assign bubble = redirect | flush | halt_q;

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (~stall),
    .bubble   (bubble),
    .hold     (stall),
    .instr_in (im.im_dout),
    .pc4_in   (pc_plus4),
    .instr_d  (instr_d),
    .pc4_d    (pc4_d),
    .valid_d  (valid_d)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural ROM and an expected-state scoreboard.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_f, instr_d, pc4_d;
  logic        valid_d, halted;
  logic [31:0] rom [1024];

  if_fetch_unit_if #(.IM_AW(10)) bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_3000), .IM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im          (bus),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc4_d       (pc4_d),
    .valid_d     (valid_d),
    .halted      (halted)
  );

  always #5 clk = ~clk;
  always_comb bus.im_dout = rom[bus.im_addr];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halt;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},    pc_f,    32'h0000_3000);
    chk({tag, "_instr"}, instr_d, 32'h0);
    chk({tag, "_pc4"},   pc4_d,   32'h0);
    chk({tag, "_valid"}, {31'b0, valid_d}, 32'h0);
    chk({tag, "_halt"},  {31'b0, halted},  32'h0);
  endtask

  // One clock: drive controls, predict the post-edge state, then compare after the edge.
  task automatic cyc(input logic s, input logic r, input logic f, input logic [31:0] rpc);
    exp_t        e;
    logic [31:0] w;
    stall = s; redirect = r; flush = f; redirect_pc = rpc;
    w = rom[m_pc[11:2]];
    if (!s) begin
      if (m_halt) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (r) begin
        m_pc = {rpc[31:2], 2'b00}; m_instr = 32'h0; m_valid = 1'b0;
      end else if (f) begin
        m_pc = m_pc + 32'd4; m_instr = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
`ifdef HALT_DETECT_EN
        if (w == 32'h0000_000C) m_halt = 1'b1;
`endif
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.halt = m_halt;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'h1, 32'h0);
    end else begin
      e = sbq.pop_front();
      chk("pc_f",    pc_f,    e.pc);
      chk("im_addr", {22'b0, bus.im_addr}, {22'b0, e.pc[11:2]});
      chk("instr_d", instr_d, e.instr);
      chk("valid_d", {31'b0, valid_d}, {31'b0, e.valid});
      chk("halted",  {31'b0, halted},  {31'b0, e.halt});
      if (e.valid) chk("pc4_d", pc4_d, e.pc4);
    end
  endtask

  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1 chk_reset_state(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + i;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    #2 chk_reset_state("rst0");
    @(negedge clk) rst = 1'b0;

    // Free-running fetch, then a two-cycle stall at 3008
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("t1_pc", pc_f, 32'h0000_3008);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("t2_hold_instr", instr_d, 32'hA000_0001);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

    // Redirect with unaligned target, then capture the target word
    cyc(0, 1, 0, 32'h0000_3043);
    chk("t3_pc", pc_f, 32'h0000_3040);
    cyc(0, 0, 0, 0);
    chk("t3_instr", instr_d, 32'hA000_0010);

    // Stall masks redirect; re-asserted redirect then takes effect
    cyc(1, 1, 0, 32'h0000_3100);
    cyc(0, 1, 0, 32'h0000_3100);
    cyc(0, 0, 0, 0);

    // Flush alone, flush with redirect, stall masking flush
    cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 32'h0000_3200);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // PC and ROM address wrap
    cyc(0, 1, 0, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap_pc", pc_f, 32'h0000_0000);
    chk("wrap_pc4", pc4_d, 32'h0000_0000);
    cyc(0, 0, 0, 0);

    // Asynchronous reset mid-cycle while a redirect is pending
    redirect = 1'b1; redirect_pc = 32'h0000_3500;
    async_reset("rst_mid");
    cyc(0, 0, 0, 0);

    // Syscall word: not a halt when stalled or flushed, halts on a normal capture
    rom[2] = 32'h0000_000C;
    cyc(0, 1, 0, 32'h0000_3008);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 32'h0000_3008);
    cyc(0, 0, 0, 0);
    chk("sys_instr", instr_d, 32'h0000_000C);
    chk("sys_valid", {31'b0, valid_d}, 32'h1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 32'h0000_3400);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
`ifdef HALT_DETECT_EN
    chk("halt_pc_frozen", pc_f, 32'h0000_300C);
`endif
    async_reset("rst_end");
    cyc(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
